commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Synthesizable successor to the bench-side commit tracer.
- Sits after the writeback/retire stage of the pipelined cpu and observes one retire slot per cycle.
- Classifies each retired instruction as reg-write, load, store, halt or other, numbers it, and buffers a trace record in a parametrised FIFO drained by a valid/ready reader.
- Also keeps cycle and instruction counters, a halt/done flag, an overflow flag and a cycle watchdog.

Parameters:
DATA_W, 16, width of pc, data, address fields
REG_W, 4, register index width
CNT_W, 32, width of cycle/instruction counters and inum field
DEPTH, 16, FIFO entries (power of two, >=2)
MAX_CYCLES, 100000, watchdog limit in cycles; 0 disables watchdog

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
trace_en  in  1  capture enable
ret_valid  in  1  retire slot holds a real instruction (0 = bubble)
ret_pc  in  DATA_W  pc of retiring instruction
ret_reg_write  in  1  register file written
ret_write_reg  in  REG_W  destination register
ret_write_data  in  DATA_W  value written
ret_mem_read  in  1  instruction is a load
ret_mem_write  in  1  instruction is a store
ret_mem_addr  in  DATA_W  memory address
ret_mem_data  in  DATA_W  store data
ret_halt  in  1  halt instruction retiring
out_valid  out  1  head record available
out_ready  in  1  reader accepts head record
out_inum  out  CNT_W  0-based instruction number
out_kind  out  2  0 other/branch/nop, 1 reg write, 2 store, 3 halt
out_load  out  1  reg-write record came from a load
out_pc  out  DATA_W  record pc
out_reg  out  REG_W  record register (0 unless kind 1)
out_value  out  DATA_W  write data (kind 1) or store data (kind 2), else 0
out_addr  out  DATA_W  address (load or store), else 0
cycle_count  out  CNT_W  cycles since reset
inst_count  out  CNT_W  retired instructions accepted
halted  out  1  halt retired (sticky)
done  out  1  halted and FIFO empty
overflow  out  1  at least one record dropped (sticky)
timeout  out  1  watchdog fired (sticky)

Behaviour:
- Reset (async, rst=1): FIFO empty, all counters 0, out_valid/halted/overflow/timeout 0, done 0, record outputs 0.
- Accept condition: ret_valid && trace_en && !halted && !timeout.
- Classification priority: halt > reg write > store > other. Kind 1 sets out_load = ret_mem_read. Fields not belonging to the kind are stored as 0.
- inum for an accepted instruction = inst_count before increment. inst_count increments on every accept, even if the record is dropped.
- Push happens on accept when the FIFO is not full, or when it is full and a pop occurs the same cycle. Otherwise the record is dropped and overflow sets.
- Pop happens when out_valid && out_ready. Output fields are the registered head entry.
- Latency: an accepted record is visible on out_* on the first edge after the push edge. There is no same-cycle bypass.
- Push and pop in the same cycle: count unchanged. At full this is legal and no drop occurs. At empty, no pop occurs (out_valid=0).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from an occupancy counter 0..DEPTH.
- cycle_count increments every cycle while !halted && !timeout, frozen otherwise. It saturates at all-ones.
- halted sets on the edge that accepts a halt. Later retires are ignored. done = halted && FIFO empty (combinational from registers).
- timeout sets when MAX_CYCLES != 0, cycle_count == MAX_CYCLES-1 and !halted on an edge. It freezes capture and counting. The FIFO stays drainable.
- trace_en=0: nothing is accepted and inst_count does not change. cycle_count still runs.
- Reset mid-operation: everything returns to reset values at once, including FIFO contents, which are discarded.

Test Plan:
- Reset then idle 5 cycles, out_ready=1 -> out_valid=0, inst_count=0, cycle_count=5, done=0.
- Retire reg write (pc 0x0000, r3=0x1234), load (pc 0x0002, r5=0xBEEF, addr 0x0040), store (pc 0x0004, addr 0x0042, data 0x0007), bubble, then nop -> four records in order: inum 0..3, kinds 1,1,2,0, out_load 0,1,x,x; inst_count=4.
- DEPTH=4, out_ready=0, 6 consecutive retires -> 4 records stored, overflow=1, inst_count=6. Drain yields inum 0..3.
- DEPTH=4 full, out_ready=1 and retire in the same cycle -> no drop, overflow stays 0, next pushed record inum=4 is emitted after the existing three.
- Halt at pc 0x0010 followed by 3 more retires -> one kind 3 record, halted=1, inst_count frozen, cycle_count frozen. done=1 after the halt record is popped.
- MAX_CYCLES=20 with no halt -> timeout=1 after the 20th edge, cycle_count=19. Assert rst mid-run -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Retire-stage commit tracer: classifies and numbers each retired instruction and
// queues a trace record in a FIFO drained by a valid/ready reader.
module commit_trace_buffer #(
  parameter int DATA_W     = 16,
  parameter int REG_W      = 4,
  parameter int CNT_W      = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_en,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_pc,
  input  logic              ret_reg_write,
  input  logic [REG_W-1:0]  ret_write_reg,
  input  logic [DATA_W-1:0] ret_write_data,
  input  logic              ret_mem_read,
  input  logic              ret_mem_write,
  input  logic [DATA_W-1:0] ret_mem_addr,
  input  logic [DATA_W-1:0] ret_mem_data,
  input  logic              ret_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_inum,
  output logic [1:0]        out_kind,
  output logic              out_load,
  output logic [DATA_W-1:0] out_pc,
  output logic [REG_W-1:0]  out_reg,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] out_addr,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic              halted,
  output logic              done,
  output logic              overflow,
  output logic              timeout
);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               OCC_W    = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic             WD_EN    = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    KIND_OTHER = 2'd0,
    KIND_REG   = 2'd1,
    KIND_STORE = 2'd2,
    KIND_HALT  = 2'd3
  } kind_e;

  typedef struct packed {
    logic [CNT_W-1:0]  inum;
    kind_e             kind;
    logic              load;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] addr;
  } rec_t;

  rec_t             r_mem [DEPTH];
  rec_t             r_head;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cycle, r_inst;
  logic             r_halted, r_overflow, r_timeout;

  rec_t             w_rec;
  logic             w_accept, w_full, w_pop, w_push, w_drop;
  logic             w_wd_fire, w_cycle_run;
  logic [OCC_W-1:0] w_left;
  logic [PTR_W-1:0] w_head_idx;

  // Classification priority: halt > reg write > store > other.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    w_rec      = '0;
    w_rec.inum = r_inst;
    w_rec.pc   = ret_pc;
    if (ret_halt) begin
      w_rec.kind = KIND_HALT;
    end else if (ret_reg_write) begin
      w_rec.kind  = KIND_REG;
      w_rec.load  = ret_mem_read;
      w_rec.rd    = ret_write_reg;
      w_rec.value = ret_write_data;
      w_rec.addr  = ret_mem_read ? ret_mem_addr : '0;
    end else if (ret_mem_write) begin
      w_rec.kind  = KIND_STORE;
      w_rec.value = ret_mem_data;
      w_rec.addr  = ret_mem_addr;
    end
  end

  assign w_accept    = ret_valid && trace_en && !r_halted && !r_timeout;
  assign w_full      = (r_count == FULL_OCC);
  assign w_pop       = r_out_valid && out_ready;
  assign w_push      = w_accept && (!w_full || w_pop);
  assign w_drop      = w_accept && !w_push;
  assign w_left      = r_count - OCC_W'(w_pop);
  assign w_head_idx  = r_rd_ptr + PTR_W'(w_pop);
  assign w_wd_fire   = WD_EN && (r_cycle == WD_LAST) && !r_halted && !r_timeout;
  assign w_cycle_run = !r_halted && !r_timeout && !w_wd_fire && (r_cycle != '1);

  // NOTE: storage is not reset; pointers and occupancy alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rec;
  end

  // The head register samples only entries written on an earlier edge, so a
  // record appears one edge after its push and never bypasses the storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_cycle     <= '0;
      r_inst      <= '0;
      r_halted    <= 1'b0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
      r_out_valid <= (w_left != '0);
      r_head      <= (w_left != '0) ? r_mem[w_head_idx] : '0;
      if (w_accept)             r_inst     <= r_inst + CNT_W'(1);
      if (w_cycle_run)          r_cycle    <= r_cycle + CNT_W'(1);
      if (w_accept && ret_halt) r_halted   <= 1'b1;
      if (w_drop)               r_overflow <= 1'b1;
      if (w_wd_fire)            r_timeout  <= 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_inum    = r_head.inum;
  assign out_kind    = r_head.kind;
  assign out_load    = r_head.load;
  assign out_pc      = r_head.pc;
  assign out_reg     = r_head.rd;
  assign out_value   = r_head.value;
  assign out_addr    = r_head.addr;
  assign cycle_count = r_cycle;
  assign inst_count  = r_inst;
  assign halted      = r_halted;
  assign done        = r_halted && (r_count == '0);
  assign overflow    = r_overflow;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: one instance without watchdog for the
// FIFO/classification tests, one with a 20-cycle watchdog.
module tb_commit_trace_buffer;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              trace_en;
  logic              ret_valid;
  logic [DATA_W-1:0] ret_pc;
  logic              ret_reg_write;
  logic [REG_W-1:0]  ret_write_reg;
  logic [DATA_W-1:0] ret_write_data;
  logic              ret_mem_read;
  logic              ret_mem_write;
  logic [DATA_W-1:0] ret_mem_addr;
  logic [DATA_W-1:0] ret_mem_data;
  logic              ret_halt;
  logic              out_ready;

  logic              out_valid, out_load, halted, done, overflow, timeout;
  logic [CNT_W-1:0]  out_inum, cycle_count, inst_count;
  logic [1:0]        out_kind;
  logic [DATA_W-1:0] out_pc, out_value, out_addr;
  logic [REG_W-1:0]  out_reg;

  logic              wd_out_valid, wd_out_load, wd_halted, wd_done, wd_overflow, wd_timeout;
  logic [CNT_W-1:0]  wd_out_inum, wd_cycle_count, wd_inst_count;
  logic [1:0]        wd_out_kind;
  logic [DATA_W-1:0] wd_out_pc, wd_out_value, wd_out_addr;
  logic [REG_W-1:0]  wd_out_reg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .MAX_CYCLES(0)
  ) u_dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_reg_write(ret_reg_write), .ret_write_reg(ret_write_reg),
    .ret_write_data(ret_write_data), .ret_mem_read(ret_mem_read),
    .ret_mem_write(ret_mem_write), .ret_mem_addr(ret_mem_addr),
    .ret_mem_data(ret_mem_data), .ret_halt(ret_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_inum(out_inum),
    .out_kind(out_kind), .out_load(out_load), .out_pc(out_pc), .out_reg(out_reg),
    .out_value(out_value), .out_addr(out_addr), .cycle_count(cycle_count),
    .inst_count(inst_count), .halted(halted), .done(done), .overflow(overflow),
    .timeout(timeout)
  );

  commit_trace_buffer #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .MAX_CYCLES(20)
  ) u_wd (
    .clk(clk), .rst(rst), .trace_en(trace_en), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_reg_write(ret_reg_write), .ret_write_reg(ret_write_reg),
    .ret_write_data(ret_write_data), .ret_mem_read(ret_mem_read),
    .ret_mem_write(ret_mem_write), .ret_mem_addr(ret_mem_addr),
    .ret_mem_data(ret_mem_data), .ret_halt(ret_halt),
    .out_valid(wd_out_valid), .out_ready(out_ready), .out_inum(wd_out_inum),
    .out_kind(wd_out_kind), .out_load(wd_out_load), .out_pc(wd_out_pc),
    .out_reg(wd_out_reg), .out_value(wd_out_value), .out_addr(wd_out_addr),
    .cycle_count(wd_cycle_count), .inst_count(wd_inst_count), .halted(wd_halted),
    .done(wd_done), .overflow(wd_overflow), .timeout(wd_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int inum, input int kind, input logic load,
                         input logic [15:0] pc, input logic [3:0] rd,
                         input logic [15:0] value, input logic [15:0] addr);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_inum"},  64'(out_inum),  64'(inum));
    chk({tag, "_kind"},  64'(out_kind),  64'(kind));
    chk({tag, "_load"},  64'(out_load),  64'(load));
    chk({tag, "_pc"},    64'(out_pc),    64'(pc));
    chk({tag, "_reg"},   64'(out_reg),   64'(rd));
    chk({tag, "_value"}, 64'(out_value), 64'(value));
    chk({tag, "_addr"},  64'(out_addr),  64'(addr));
  endtask

  task automatic set_ret(input logic [15:0] pc, input logic rw, input logic [3:0] wr,
                         input logic [15:0] wd, input logic mr, input logic mw,
                         input logic [15:0] addr, input logic [15:0] md, input logic hlt);
    ret_valid      = 1'b1;
    ret_pc         = pc;
    ret_reg_write  = rw;
    ret_write_reg  = wr;
    ret_write_data = wd;
    ret_mem_read   = mr;
    ret_mem_write  = mw;
    ret_mem_addr   = addr;
    ret_mem_data   = md;
    ret_halt       = hlt;
  endtask

  task automatic clr_ret();
    set_ret(16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    ret_valid = 1'b0;
  endtask

  // Reset asserted just after a falling edge, released on the next falling edge.
  task automatic do_reset();
    rst = 1'b1;
    clr_ret();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    trace_en  = 1'b1;
    out_ready = 1'b1;
    clr_ret();

    // Reset state, then 5 idle edges.
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid",    64'(out_valid),   64'd0);
    chk("rst_inst",     64'(inst_count),  64'd0);
    chk("rst_cycle",    64'(cycle_count), 64'd0);
    chk("rst_done",     64'(done),        64'd0);
    chk("rst_overflow", 64'(overflow),    64'd0);
    chk("rst_timeout",  64'(wd_timeout),  64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_valid", 64'(out_valid),   64'd0);
    chk("idle_inst",  64'(inst_count),  64'd0);
    chk("idle_cycle", 64'(cycle_count), 64'd5);
    chk("idle_done",  64'(done),        64'd0);

    // Reg write, load, store, bubble, nop.
    out_ready = 1'b0;
    set_ret(16'h0000, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    chk("t2_no_bypass", 64'(out_valid), 64'd0);
    set_ret(16'h0002, 1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0);
    @(negedge clk);
    chk("t2_latency", 64'(out_valid), 64'd1);
    set_ret(16'h0004, 1'b0, 4'd9, 16'hAAAA, 1'b0, 1'b1, 16'h0042, 16'h0007, 1'b0);
    @(negedge clk);
    set_ret(16'h0008, 1'b1, 4'd7, 16'h7777, 1'b0, 1'b1, 16'h0050, 16'h0001, 1'b1);
    ret_valid = 1'b0;
    @(negedge clk);
    set_ret(16'h0006, 1'b0, 4'd2, 16'h5555, 1'b0, 1'b0, 16'h0055, 16'h0066, 1'b0);
    @(negedge clk);
    clr_ret();
    chk("t2_inst",     64'(inst_count), 64'd4);
    chk("t2_overflow", 64'(overflow),   64'd0);
    out_ready = 1'b1;
    chk_rec("t2_r0", 0, 1, 1'b0, 16'h0000, 4'd3, 16'h1234, 16'h0000);
    @(negedge clk);
    chk_rec("t2_r1", 1, 1, 1'b1, 16'h0002, 4'd5, 16'hBEEF, 16'h0040);
    @(negedge clk);
    chk_rec("t2_r2", 2, 2, 1'b0, 16'h0004, 4'd0, 16'h0007, 16'h0042);
    @(negedge clk);
    chk_rec("t2_r3", 3, 0, 1'b0, 16'h0006, 4'd0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("t2_empty", 64'(out_valid), 64'd0);

    // Overflow: six retires into a 4-deep FIFO with no reader.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) chk("t3_no_ovf_yet", 64'(overflow), 64'd0);
      set_ret(16'h0100 + 16'(2 * i), 1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
    end
    clr_ret();
    chk("t3_overflow", 64'(overflow),   64'd1);
    chk("t3_inst",     64'(inst_count), 64'd6);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_rec($sformatf("t3_r%0d", i), i, 1, 1'b0, 16'h0100 + 16'(2 * i), 4'(i),
              16'h1000 + 16'(i), 16'h0000);
      @(negedge clk);
    end
    chk("t3_empty", 64'(out_valid), 64'd0);

    // Full FIFO: pop and push on the same edge, no drop.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ret(16'h0200 + 16'(2 * i), 1'b1, 4'(i), 16'h2000 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
    end
    chk("t4_full_head", 64'(out_inum), 64'd0);
    out_ready = 1'b1;
    set_ret(16'h0208, 1'b1, 4'd4, 16'h2004, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    clr_ret();
    chk("t4_overflow", 64'(overflow),   64'd0);
    chk("t4_inst",     64'(inst_count), 64'd5);
    for (int i = 1; i < 5; i++) begin
      chk_rec($sformatf("t4_r%0d", i), i, 1, 1'b0, 16'h0200 + 16'(2 * i), 4'(i),
              16'h2000 + 16'(i), 16'h0000);
      @(negedge clk);
    end
    chk("t4_empty", 64'(out_valid), 64'd0);

    // Halt with later retires ignored; counters freeze.
    do_reset();
    out_ready = 1'b0;
    set_ret(16'h0010, 1'b1, 4'd6, 16'h6666, 1'b0, 1'b1, 16'h0070, 16'h0080, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      set_ret(16'h0012 + 16'(2 * i), 1'b1, 4'd1, 16'h0011, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
    end
    clr_ret();
    chk("t5_halted", 64'(halted),      64'd1);
    chk("t5_inst",   64'(inst_count),  64'd1);
    chk("t5_cycle",  64'(cycle_count), 64'd1);
    chk("t5_done0",  64'(done),        64'd0);
    chk_rec("t5_rec", 0, 3, 1'b0, 16'h0010, 4'd0, 16'h0000, 16'h0000);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_empty", 64'(out_valid),   64'd0);
    chk("t5_done1", 64'(done),        64'd1);
    chk("t5_cycle_frozen", 64'(cycle_count), 64'd1);

    // Watchdog at 20 cycles, then asynchronous reset mid-run.
    do_reset();
    out_ready = 1'b0;
    set_ret(16'h0030, 1'b1, 4'd1, 16'h0AAA, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    clr_ret();
    repeat (18) @(negedge clk);
    chk("t6_pre_timeout", 64'(wd_timeout),     64'd0);
    chk("t6_pre_cycle",   64'(wd_cycle_count), 64'd19);
    @(negedge clk);
    chk("t6_timeout", 64'(wd_timeout),     64'd1);
    chk("t6_cycle",   64'(wd_cycle_count), 64'd19);
    set_ret(16'h0032, 1'b1, 4'd2, 16'h0BBB, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    clr_ret();
    chk("t6_inst_frozen",  64'(wd_inst_count),  64'd1);
    chk("t6_cycle_frozen", 64'(wd_cycle_count), 64'd19);
    chk("t6_drain_valid",  64'(wd_out_valid),   64'd1);
    chk("t6_drain_pc",     64'(wd_out_pc),      64'h0030);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t6_drained",    64'(wd_out_valid), 64'd0);
    chk("t6_pre_valid",  64'(out_valid),    64'd1);
    chk("t6_pre_pc",     64'(out_pc),       64'h0032);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid",    64'(out_valid),      64'd0);
    chk("arst_pc",       64'(out_pc),         64'd0);
    chk("arst_inum",     64'(out_inum),       64'd0);
    chk("arst_value",    64'(out_value),      64'd0);
    chk("arst_inst",     64'(inst_count),     64'd0);
    chk("arst_cycle",    64'(cycle_count),    64'd0);
    chk("arst_timeout",  64'(wd_timeout),     64'd0);
    chk("arst_wd_cycle", 64'(wd_cycle_count), 64'd0);
    chk("arst_wd_inst",  64'(wd_inst_count),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_discarded", 64'(out_valid),   64'd0);
    chk("arst_cycle_run", 64'(cycle_count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
